// File: rtl/cpm_gen2.sv
// Configurable packet modifier: transforms payloads per programmed mode and queues them
// in an in-order FIFO with per-entry latency countdown, controlled over a register bus.
module cpm_gen2 #(
    parameter int DATA_W  = 16,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int LAT     = 1,
    parameter int ROT_AMT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_id,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_payload,
    input  logic              req,
    output logic              gnt,
    input  logic              write_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int AW  = $clog2(DEPTH);
    localparam int ROT = ROT_AMT % DATA_W;

    logic              enable;
    logic [1:0]        mode;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] addc;
    logic              drop_en;
    logic [15:0]       bitmap;
    logic [31:0]       count_in;
    logic [31:0]       count_out;
    logic [31:0]       dropped;

    logic [ID_W-1:0]   id_mem  [DEPTH];
    logic [3:0]        op_mem  [DEPTH];
    logic [DATA_W-1:0] pay_mem [DEPTH];
    logic [2:0]        cd_mem  [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       level;

    logic full, empty, in_fire, out_fire, wr_sel, soft_rst, drop_hit, push, pop;
    logic [DATA_W-1:0] xformed;
    logic [DATA_W-1:0] rotated;
    logic [2:0]        cd_new;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign in_ready = enable && !full;
    assign out_valid = enable && !empty && (cd_mem[rd_ptr] == 3'd0);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign gnt      = req;
    assign wr_sel   = req && write_en;
    assign soft_rst = wr_sel && (addr == 8'h00) && wdata[1];
    assign drop_hit = drop_en && bitmap[in_opcode];
    // A soft reset swallows any handshake in the same cycle.
    assign push     = in_fire && !drop_hit && !soft_rst;
    assign pop      = out_fire && !soft_rst;

    always_comb begin
        rotated = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rotated[(i + ROT) % DATA_W] = in_payload[i];
        end
    end

    // Transform is applied at acceptance, so later config writes cannot touch queued entries.
    always_comb begin
        xformed = in_payload;
        cd_new  = 3'(LAT);
        case (mode)
            2'd0: cd_new  = 3'd0;
            2'd1: xformed = in_payload ^ mask;
            2'd2: xformed = in_payload + addc;
            default: xformed = rotated;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable  <= 1'b0;
            mode    <= '0;
            mask    <= '0;
            addc    <= '0;
            drop_en <= 1'b0;
            bitmap  <= '0;
        end else if (wr_sel) begin
            case (addr)
                8'h00: enable <= wdata[0];
                8'h04: mode   <= wdata[1:0];
                8'h08: mask   <= wdata[DATA_W-1:0];
                8'h0C: addc   <= wdata[DATA_W-1:0];
                8'h10: begin
                    drop_en <= wdata[0];
                    bitmap  <= wdata[31:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            count_in  <= '0;
            count_out <= '0;
            dropped   <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                count_in <= count_in + 32'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                count_out <= count_out + 32'd1;
            end
            if (in_fire && drop_hit) dropped <= dropped + 32'd1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // NOTE: storage is not reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cd_mem[i] != 3'd0) cd_mem[i] <= cd_mem[i] - 3'd1;
            end
        end
        if (push) begin
            id_mem[wr_ptr]  <= in_id;
            op_mem[wr_ptr]  <= in_opcode;
            pay_mem[wr_ptr] <= xformed;
            cd_mem[wr_ptr]  <= cd_new;
        end
    end

    assign out_id      = out_valid ? id_mem[rd_ptr]  : '0;
    assign out_opcode  = out_valid ? op_mem[rd_ptr]  : '0;
    assign out_payload = out_valid ? pay_mem[rd_ptr] : '0;

    always_comb begin
        rdata = '0;
        case (addr)
            8'h00: rdata[0] = enable;
            8'h04: rdata[1:0] = mode;
            8'h08: rdata = 32'(mask);
            8'h0C: rdata = 32'(addc);
            8'h10: rdata = {bitmap, 15'd0, drop_en};
            8'h14: begin
                rdata[0]    = !empty;
                rdata[1]    = full;
                rdata[2]    = empty;
                rdata[15:8] = 8'(level);
            end
            8'h18: rdata = count_in;
            8'h1C: rdata = count_out;
            8'h20: rdata = dropped;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpm_gen2.sv
// Bench for cpm_gen2: directed scenarios plus random traffic, all checked against a
// queue-based cycle model of the packet modifier.
module tb_cpm_gen2;
    localparam int DATA_W = 16, ID_W = 4, DEPTH = 4, LAT = 1, ROT_AMT = 4;

    logic              clk, rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [ID_W-1:0]   in_id, out_id;
    logic [3:0]        in_opcode, out_opcode;
    logic [DATA_W-1:0] in_payload, out_payload;
    logic              req, gnt, write_en;
    logic [7:0]        addr;
    logic [31:0]       wdata, rdata;

    cpm_gen2 #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .LAT(LAT), .ROT_AMT(ROT_AMT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_opcode(in_opcode), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_opcode(out_opcode), .out_payload(out_payload),
        .req(req), .gnt(gnt), .write_en(write_en), .addr(addr),
        .wdata(wdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; int op; int pay; int cd; } ent_t;
    ent_t q[$];

    int total = 0;
    int bad = 0;
    bit m_live = 0;
    bit last_in_fire;
    int m_en, m_mode, m_mask, m_addc, m_dropen, m_bitmap;
    logic [31:0] m_cin, m_cout, m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int xform(input int mode, input int pay);
        int w = 1 << DATA_W;
        int r = ROT_AMT % DATA_W;
        case (mode)
            0: return pay;
            1: return pay ^ m_mask;
            2: return (pay + m_addc) % w;
            default: return ((pay * (1 << r)) % w) + pay / (1 << (DATA_W - r));
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        int lvl = q.size();
        case (a)
            8'h00: return 32'(m_en);
            8'h04: return 32'(m_mode);
            8'h08: return 32'(m_mask);
            8'h0C: return 32'(m_addc);
            8'h10: return 32'(m_bitmap) * 65536 + 32'(m_dropen);
            8'h14: return 32'(lvl * 256 + (lvl == 0 ? 4 : 0) + (lvl == DEPTH ? 2 : 0) + (lvl != 0 ? 1 : 0));
            8'h18: return m_cin;
            8'h1C: return m_cout;
            8'h20: return m_drop;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit pred_ir();
        return m_en != 0 && q.size() < DEPTH;
    endfunction

    function automatic bit pred_ov();
        return m_en != 0 && q.size() > 0 && q[0].cd == 0;
    endfunction

    task automatic model_clear();
        q.delete();
        m_cin = 0; m_cout = 0; m_drop = 0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model, then step past the rising edge.
    task automatic cycle();
        bit ir, ov, fire_in, fire_out;
        @(negedge clk);
        ir = pred_ir();
        ov = pred_ov();
        if (m_live) begin
            check("in_ready", in_ready, ir);
            check("out_valid", out_valid, ov);
            check("gnt", gnt, req);
            if (ov) begin
                check("out_id", out_id, q[0].id);
                check("out_opcode", out_opcode, q[0].op);
                check("out_payload", out_payload, q[0].pay);
            end
            if (req && !write_en) check($sformatf("rdata@%h", addr), rdata, model_rd(addr));
        end
        fire_in  = in_valid && ir;
        fire_out = ov && out_ready;
        last_in_fire = fire_in;
        if (rst) begin
            model_clear();
            m_en = 0; m_mode = 0; m_mask = 0; m_addc = 0; m_dropen = 0; m_bitmap = 0;
            m_live = 1;
        end else if (req && write_en && addr == 8'h00 && wdata[1]) begin
            model_clear();
            m_en = int'(wdata[0]);
        end else begin
            if (fire_out) begin
                void'(q.pop_front());
                m_cout++;
            end
            foreach (q[i]) if (m_en != 0 && q[i].cd > 0) q[i].cd = q[i].cd - 1;
            if (fire_in) begin
                if (m_dropen != 0 && ((m_bitmap >> in_opcode) & 1) != 0) m_drop++;
                else begin
                    q.push_back('{int'(in_id), int'(in_opcode), xform(m_mode, int'(in_payload)),
                                  (m_mode == 0) ? 0 : LAT});
                    m_cin++;
                end
            end
            if (req && write_en) begin
                case (addr)
                    8'h00: m_en = int'(wdata[0]);
                    8'h04: m_mode = int'(wdata[1:0]);
                    8'h08: m_mask = int'(wdata[15:0]);
                    8'h0C: m_addc = int'(wdata[15:0]);
                    8'h10: begin m_dropen = int'(wdata[0]); m_bitmap = int'(wdata[31:16]); end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        req = 1; write_en = 1; addr = a; wdata = d;
        cycle();
        req = 0; write_en = 0;
    endtask

    task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] exp);
        req = 1; write_en = 0; addr = a;
        #1;
        check(tag, rdata, exp);
        cycle();
        req = 0;
    endtask

    task automatic send(input int id, input int op, input int pay);
        in_valid = 1; in_id = ID_W'(id); in_opcode = 4'(op); in_payload = DATA_W'(pay);
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (last_in_fire) break;
        end
        check("send_accepted", last_in_fire, 1'b1);
        in_valid = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; in_id = 0; in_opcode = 0; in_payload = 0;
        req = 0; write_en = 0; addr = 0; wdata = 0;
        cycle();
        cycle();
        rst = 0;
        check("rst_out_payload", out_payload, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        rd_exp("rst_status", 8'h14, 32'h0000_0004);
        rd_exp("rst_ctrl", 8'h00, 32'h0);

        // Mode 0 passthrough.
        wr(8'h00, 32'h1);
        out_ready = 1;
        send(1, 0, 16'h1234); check("m0_vis", out_payload, 16'h1234);
        send(2, 0, 16'h0001); check("m0_vis2", out_payload, 16'h0001);
        send(3, 0, 16'hFFFF); check("m0_vis3", out_payload, 16'hFFFF);
        idle(2);
        rd_exp("m0_cin", 8'h18, 32'd3);
        rd_exp("m0_cout", 8'h1C, 32'd3);

        // Mode 2 add with wrap, then mode 3 rotate.
        wr(8'h04, 32'h2); wr(8'h0C, 32'h0002);
        send(4, 1, 16'hFFFF);
        check("m2_wait", out_valid, 1'b0);
        cycle();
        check("m2_ready", out_valid, 1'b1);
        check("m2_pay", out_payload, 16'h0001);
        idle(2);
        wr(8'h04, 32'h3);
        send(5, 2, 16'h1234);
        idle(1);
        check("m3_pay", out_payload, 16'h2341);
        idle(2);

        // Fill to full with no downstream, then release one pop.
        wr(8'h04, 32'h0);
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) send(i, i, 16'h0100 + i);
        check("full_in_ready", in_ready, 1'b0);
        rd_exp("full_status", 8'h14, 32'h0000_0403);
        out_ready = 1; cycle(); out_ready = 0;
        check("after_pop_ready", in_ready, 1'b1);
        out_ready = 1; idle(6);

        // Opcode drop bitmap.
        wr(8'h00, 32'h3);
        wr(8'h10, 32'h0020_0001);
        send(6, 5, 16'hAAAA); send(7, 3, 16'hBBBB); send(8, 5, 16'hCCCC);
        idle(2);
        rd_exp("drop_cnt", 8'h20, 32'd2);
        rd_exp("drop_cin", 8'h18, 32'd1);
        wr(8'h10, 32'h0);

        // Snapshot of config at acceptance.
        wr(8'h04, 32'h1); wr(8'h08, 32'h00FF);
        out_ready = 0;
        send(9, 1, 16'h0F0F);
        wr(8'h04, 32'h0);
        check("snap_pay", out_payload, 16'h0FF0);
        out_ready = 1; idle(2);

        // Pause, resume, then soft reset.
        out_ready = 0;
        send(10, 1, 16'h1111); send(11, 2, 16'h2222);
        wr(8'h00, 32'h0);
        check("pause_ov", out_valid, 1'b0);
        check("pause_ir", in_ready, 1'b0);
        idle(5);
        wr(8'h00, 32'h1);
        out_ready = 1; idle(4);
        out_ready = 0;
        send(12, 0, 16'h3333);
        in_valid = 1;
        wr(8'h00, 32'h3);
        in_valid = 0;
        rd_exp("srst_status", 8'h14, 32'h0000_0004);
        rd_exp("srst_cin", 8'h18, 32'd0);
        rd_exp("srst_mask", 8'h08, 32'h0000_00FF);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            in_valid = 1'($urandom_range(0, 1));
            in_id = ID_W'($urandom); in_opcode = 4'($urandom); in_payload = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 799) == 0);
            req = 0; write_en = 0;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                req = 1; write_en = 1;
                case ($urandom_range(0, 4))
                    0: begin
                        addr = 8'h00;
                        wdata = {30'd0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0)};
                    end
                    1: begin addr = 8'h04; wdata = $urandom; end
                    2: begin addr = 8'h08; wdata = $urandom; end
                    3: begin addr = 8'h0C; wdata = $urandom; end
                    default: begin addr = 8'h10; wdata = $urandom; end
                endcase
            end else if (r < 5) begin
                req = 1;
                addr = 8'(4 * $urandom_range(0, 9));
            end
            cycle();
            if (m_en == 0 && $urandom_range(0, 3) == 0) begin
                rst = 0; req = 1; write_en = 1; addr = 8'h00; wdata = 32'h1;
                cycle();
            end
        end
        rst = 0; req = 0; write_en = 0; in_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpm_gen2.md
Name: cpm_gen2

Overview:
Second-generation configurable packet modifier. Accepts {id, opcode, payload} beats on a valid/ready stream and transforms each payload by the programmed mode (pass/XOR/add/rotate). Buffers results in a parametrised in-order FIFO with per-entry latency countdown. Provides a 16-entry opcode drop bitmap, pause-without-flush, accurate in/out/drop counters and FIFO level status over a single-cycle register bus.

Parameters:
DATA_W, 16, payload width (1..32)
ID_W, 4, id width
DEPTH, 4, FIFO entries (power of 2, 2..64)
LAT, 1, extra countdown cycles for modes 1-3 (0..7)
ROT_AMT, 4, left-rotate amount for mode 3 (taken mod DATA_W)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input accepted when in_valid&&in_ready
in_id  in  ID_W  packet id
in_opcode  in  4  packet opcode
in_payload  in  DATA_W  payload
out_valid  out  1  head entry presentable
out_ready  in  1  downstream accept
out_id  out  ID_W  head id
out_opcode  out  4  head opcode
out_payload  out  DATA_W  head transformed payload
req  in  1  register access request
gnt  out  1  equals req (same cycle)
write_en  in  1  1=write, 0=read
addr  in  8  byte address
wdata  in  32  write data
rdata  out  32  combinational read data for addr

Behaviour:
- Reset: all registers, FIFO pointers, level and counters 0. Outputs: in_ready=0, out_valid=0, out_id/opcode/payload=0, rdata = decode of addr over reset state.
- Register map (writes on req&&write_en; unmapped reads 0, writes ignored):
  0x00 CTRL: [0] enable RW; [1] soft_rst W1 pulse, reads 0.
  0x04 MODE: [1:0] RW.
  0x08 MASK: [DATA_W-1:0] RW.
  0x0C ADDC: [DATA_W-1:0] RW.
  0x10 DROP: [0] drop_en RW; [31:16] opcode bitmap RW.
  0x14 STATUS RO: [0] busy=(level!=0); [1] full; [2] empty; [15:8] level.
  0x18 COUNT_IN, 0x1C COUNT_OUT, 0x20 DROPPED: RO, 32-bit, wrap at 2^32.
- Modes: 0 = pass, cd=0; 1 = payload^MASK; 2 = (payload+ADDC) mod 2^DATA_W; 3 = rotate-left ROT_AMT. Modes 1-3 load cd=LAT.
- MODE, MASK and ADDC are snapshotted at acceptance. Later writes never alter queued entries.
- Handshake: in_ready = enable && !full. Full state blocks input even if out_fire occurs in the same cycle (no bypass).
- in_fire = in_valid&&in_ready.
  - If drop_en && bitmap[in_opcode]: DROPPED+1, nothing enqueued.
  - Otherwise: enqueue at tail and COUNT_IN+1.
- out_valid = enable && !empty && head.cd==0. out_fire = out_valid&&out_ready pops head and increments COUNT_OUT.
- Latency: each valid entry's cd decrements by 1 per cycle while enable=1, saturating at 0. A mode-0 beat is visible 1 cycle after acceptance; modes 1-3 after LAT+1 cycles. Order is strictly FIFO: a ready younger entry waits behind the head.
- Simultaneous push and pop: level unchanged, pointers wrap mod DEPTH.
- enable=0 pauses: in_ready=0, out_valid=0, cd frozen, contents kept. Resumes intact on re-enable.
- soft_rst write: next cycle the FIFO is flushed, COUNT_*/DROPPED are cleared, and any same-cycle in_fire is discarded. Config registers are kept. No stream activity in that cycle.
- rst mid-operation clears everything regardless of pending handshakes.

Test Plan:
- Mode 0, enable, send 3 beats payload 0x1234,0x0001,0xFFFF with out_ready=1 -> each appears 1 cycle after acceptance, unchanged, in order; COUNT_IN=COUNT_OUT=3.
- Mode 2, ADDC=0x0002, LAT=1, payload 0xFFFF -> out_payload 0x0001 exactly 2 cycles after in_fire. Mode 3 with 0x1234 -> 0x2341.
- out_ready=0, push DEPTH=4 beats -> in_ready drops after 4th, STATUS.full=1, level=4. Release one pop -> in_ready=1 the following cycle.
- DROP bitmap=0x0020, drop_en=1, send opcodes 5,3,5 -> DROPPED=2, COUNT_IN=1, only opcode 3 emerges.
- Mode 1, MASK=0x00FF, enqueue 0x0F0F, then write MODE=0 before pop -> output 0x0FF0 (snapshot held).
- 2 entries queued, write CTRL enable=0 for 5 cycles then enable=1 -> entries delivered intact. Then write soft_rst -> level=0 and counters 0 next cycle; MASK retained.
